// File: rtl/cpu_controller_if.sv
// Bus between the CPU sequencing controller and its datapath.
// Opcode encoding shared by the controller and whatever drives the IR.
typedef enum logic [2:0] {
  OP_HLT = 3'd0,
  OP_SKZ = 3'd1,
  OP_ADD = 3'd2,
  OP_AND = 3'd3,
  OP_XOR = 3'd4,
  OP_LDA = 3'd5,
  OP_STO = 3'd6,
  OP_JMP = 3'd7
} opcode_t;

interface cpu_controller_if #(
  parameter int INSTR_CNT_W = 16
);
  // Datapath status and operator controls into the controller
  opcode_t                opcode;
  logic                   zero;
  logic                   run_en;
  logic                   step;

  // Datapath strobes and status out of the controller
  logic                   sel;
  logic                   rd;
  logic                   ld_ir;
  logic                   inc_pc;
  logic                   halt;
  logic                   ld_pc;
  logic                   data_e;
  logic                   ld_ac;
  logic                   wr;
  logic [2:0]             phase;
  logic                   halted;
  logic [INSTR_CNT_W-1:0] instr_cnt;

  // The controller side drives the strobes
  modport master (
    input  opcode, zero, run_en, step,
    output sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
    output phase, halted, instr_cnt
  );

  // The datapath / operator side drives opcode, flags and run controls
  modport slave (
    output opcode, zero, run_en, step,
    input  sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr,
    input  phase, halted, instr_cnt
  );
endinterface

// File: rtl/cpu_controller.sv
// Eight-phase instruction sequencer for a simple accumulator CPU, with
// sticky halt, single-step support and a retired-instruction counter.
module cpu_controller #(
  parameter int INSTR_CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  cpu_controller_if.master bus
);

  typedef enum logic [2:0] {
    INST_ADDR  = 3'd0,
    INST_FETCH = 3'd1,
    INST_LOAD  = 3'd2,
    IDLE       = 3'd3,
    OP_ADDR    = 3'd4,
    OP_FETCH   = 3'd5,
    ALU_OP     = 3'd6,
    STORE      = 3'd7
  } phase_e;

  phase_e                 phase_q, phase_d;
  logic                   halted_q, halted_d;
  logic                   step_pending_q, step_pending_d;
  logic [INSTR_CNT_W-1:0] instr_cnt_q, instr_cnt_d;

  logic alu_op;
  logic is_hlt, is_skz, is_sto, is_jmp;

  logic sel, rd, ld_ir, inc_pc, halt, ld_pc, data_e, ld_ac, wr;

  assign is_hlt = (bus.opcode == OP_HLT);
  assign is_skz = (bus.opcode == OP_SKZ);
  assign is_sto = (bus.opcode == OP_STO);
  assign is_jmp = (bus.opcode == OP_JMP);
  assign alu_op = (bus.opcode == OP_ADD) || (bus.opcode == OP_AND) ||
                  (bus.opcode == OP_XOR) || (bus.opcode == OP_LDA);

  // State register: reset drops straight back to the first fetch phase
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q        <= INST_ADDR;
      halted_q       <= 1'b0;
      step_pending_q <= 1'b0;
      instr_cnt_q    <= '0;
    end else begin
      phase_q        <= phase_d;
      halted_q       <= halted_d;
      step_pending_q <= step_pending_d;
      instr_cnt_q    <= instr_cnt_d;
    end
  end

  // Next-state: walk the phases, gating the start of each instruction on run/step
  always_comb begin
    phase_d        = phase_q;
    halted_d       = halted_q;
    step_pending_d = step_pending_q;
    instr_cnt_d    = instr_cnt_q;
    if (!halted_q) begin
      if (bus.step) begin
        step_pending_d = 1'b1;
      end
      unique case (phase_q)
        INST_ADDR: begin
          if (bus.run_en || step_pending_q) begin
            phase_d        = INST_FETCH;
            step_pending_d = 1'b0;
          end
        end
        INST_FETCH: phase_d = INST_LOAD;
        INST_LOAD:  phase_d = IDLE;
        IDLE:       phase_d = OP_ADDR;
        OP_ADDR: begin
          if (is_hlt) begin
            halted_d = 1'b1;
          end else begin
            phase_d = OP_FETCH;
          end
        end
        OP_FETCH:   phase_d = ALU_OP;
        ALU_OP:     phase_d = STORE;
        STORE: begin
          phase_d     = INST_ADDR;
          instr_cnt_d = instr_cnt_q + INSTR_CNT_W'(1);
        end
        default:    phase_d = INST_ADDR;
      endcase
    end
  end

  // Output decode: datapath strobes from phase and opcode, silenced while halted
  always_comb begin
    sel    = 1'b0;
    rd     = 1'b0;
    ld_ir  = 1'b0;
    inc_pc = 1'b0;
    halt   = 1'b0;
    ld_pc  = 1'b0;
    data_e = 1'b0;
    ld_ac  = 1'b0;
    wr     = 1'b0;
    if (halted_q) begin
      halt = 1'b1;
    end else begin
      unique case (phase_q)
        INST_ADDR: begin
          sel = 1'b1;
        end
        INST_FETCH: begin
          sel = 1'b1;
          rd  = 1'b1;
        end
        INST_LOAD, IDLE: begin
          sel   = 1'b1;
          rd    = 1'b1;
          ld_ir = 1'b1;
        end
        OP_ADDR: begin
          inc_pc = 1'b1;
          halt   = is_hlt;
        end
        OP_FETCH: begin
          rd = alu_op;
        end
        ALU_OP: begin
          rd     = alu_op;
          inc_pc = is_skz && bus.zero;
          ld_pc  = is_jmp;
          data_e = is_sto;
        end
        STORE: begin
          rd     = alu_op;
          ld_ac  = alu_op;
          ld_pc  = is_jmp;
          wr     = is_sto;
          data_e = is_sto;
        end
        default: begin
          sel = 1'b0;
        end
      endcase
    end
  end

  assign bus.sel       = sel;
  assign bus.rd        = rd;
  assign bus.ld_ir     = ld_ir;
  assign bus.inc_pc    = inc_pc;
  assign bus.halt      = halt;
  assign bus.ld_pc     = ld_pc;
  assign bus.data_e    = data_e;
  assign bus.ld_ac     = ld_ac;
  assign bus.wr        = wr;
  assign bus.phase     = phase_q;
  assign bus.halted    = halted_q;
  assign bus.instr_cnt = instr_cnt_q;

endmodule
